set_assoc_cached_memory: RTL and testbench

Parametrised successor to the single-way data cache. N-way set-associative, write-through, no-write-allocate cache between the core's load/store port and a variable-latency backing data memory, using a req/ack handshake. Supports word and byte accesses, LRU replacement and hit/miss counters. Stalls the core via `ready` on misses and on all writes.

---
 rtl/cache_pkg.sv | 9 +
 rtl/cache_set_array.sv | 73 +++++++
 rtl/set_assoc_cached_memory.sv | 96 +++++++++
 tb/tb_set_assoc_cached_memory.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// cache_pkg: shared FSM state type, memory access-type codes and address field helper
package cache_pkg;
  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT, RESP} cache_state_t;
  localparam logic MEM_WORD = 1'b0;
  localparam logic MEM_BYTE = 1'b1;
  function automatic logic [63:0] addr_field(input logic [63:0] a, input int lsb, input int w);
    return (a >> lsb) & ((64'd1 << w) - 64'd1);
  endfunction
endpackage

// File: rtl/cache_set_array.sv
// cache_set_array: valid/tag/data/LRU storage with combinational lookup and registered write port
module cache_set_array #(
  parameter int SET_WIDTH = 3,
  parameter int TAG_WIDTH = 27,
  parameter int DATA_WIDTH = 32,
  parameter int WAYS = 2,
  localparam int WW = WAYS > 1 ? $clog2(WAYS) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [SET_WIDTH-1:0]  set_idx,
  input  logic [TAG_WIDTH-1:0]  tag,
  output logic                  hit,
  output logic [WW-1:0]         hit_way,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [WW-1:0]         victim,
  input  logic                  wr_en,
  input  logic [WW-1:0]         wr_way,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  touch,
  input  logic [WW-1:0]         touch_way
);
  localparam int SETS = 1 << SET_WIDTH;
  logic [WAYS-1:0] valid [SETS];
  logic [TAG_WIDTH-1:0] tags [SETS][WAYS];
  logic [DATA_WIDTH-1:0] data [SETS][WAYS];
  logic [WW-1:0] lru_victim;
  // descending scan so the lowest-indexed invalid way wins the victim choice
  always_comb begin
    hit = 1'b0;
    hit_way = '0;
    rdata = '0;
    victim = lru_victim;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (!valid[set_idx][i]) victim = WW'(i);
      if (valid[set_idx][i] && tags[set_idx][i] == tag) begin
        hit = 1'b1;
        hit_way = WW'(i);
        rdata = data[set_idx][i];
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) for (int s = 0; s < SETS; s++) valid[s] <= '0;
    else if (wr_en) valid[set_idx][wr_way] <= 1'b1;
  always_ff @(posedge clk)
    if (wr_en) begin
      tags[set_idx][wr_way] <= tag;
      data[set_idx][wr_way] <= wr_data;
    end
  generate
    if (WAYS == 4) begin : g_plru
      // bit0 picks the victim pair, bit1/bit2 the victim within the left/right pair
      logic [2:0] tree [SETS];
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) for (int s = 0; s < SETS; s++) tree[s] <= '0;
        else if (touch) begin
          tree[set_idx][0] <= ~touch_way[1];
          if (touch_way[1]) tree[set_idx][2] <= ~touch_way[0];
          else tree[set_idx][1] <= ~touch_way[0];
        end
      assign lru_victim = tree[set_idx][0] ? {1'b1, tree[set_idx][2]} : {1'b0, tree[set_idx][1]};
    end else if (WAYS == 2) begin : g_lru
      logic lru [SETS];
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) for (int s = 0; s < SETS; s++) lru[s] <= 1'b0;
        else if (touch) lru[set_idx] <= ~touch_way[0];
      assign lru_victim = lru[set_idx];
    end else begin : g_direct
      assign lru_victim = '0;
    end
  endgenerate
endmodule

// File: rtl/set_assoc_cached_memory.sv
// set_assoc_cached_memory: N-way write-through, no-write-allocate cache with req/ack backing memory
module set_assoc_cached_memory
  import cache_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int SET_WIDTH = 3,
  parameter int WAYS = 2,
  parameter int OFFSET_WIDTH = 2,
  parameter int CNT_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] Write_Data,
  input  logic                  WE,
  input  logic                  MemType,
  output logic [DATA_WIDTH-1:0] Data_o,
  output logic                  ready,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic                  mem_type,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ack,
  output logic [CNT_WIDTH-1:0]  hit_count,
  output logic [CNT_WIDTH-1:0]  miss_count
);
  localparam int TAG_WIDTH = ADDR_WIDTH - SET_WIDTH - OFFSET_WIDTH;
  localparam int WW = WAYS > 1 ? $clog2(WAYS) : 1;
  cache_state_t state;
  logic [SET_WIDTH-1:0] set_idx;
  logic [TAG_WIDTH-1:0] tag;
  logic [OFFSET_WIDTH-1:0] lane;
  logic hit, load_hit, fill, wr_en, touch;
  logic [WW-1:0] hit_way, victim, wr_way;
  logic [DATA_WIDTH-1:0] rdata, merged, wr_data, resp, resp_src;
  assign set_idx = SET_WIDTH'(addr_field(64'(addr), OFFSET_WIDTH, SET_WIDTH));
  assign tag = TAG_WIDTH'(addr_field(64'(addr), OFFSET_WIDTH + SET_WIDTH, TAG_WIDTH));
  assign lane = addr[OFFSET_WIDTH-1:0];
  assign load_hit = state == IDLE && req_valid && !WE && hit;
  assign fill = state == RD_WAIT && mem_ack;
  assign wr_en = fill || (state == WR_WAIT && mem_ack && hit);
  assign wr_way = fill ? victim : hit_way;
  assign wr_data = fill ? mem_rdata : merged;
  assign touch = wr_en || load_hit;
  always_comb begin
    merged = Write_Data;
    if (MemType == MEM_BYTE) begin
      merged = rdata;
      merged[8*lane +: 8] = Write_Data[7:0];
    end
  end
  assign resp_src = state == RESP ? resp : rdata;
  assign ready = load_hit || state == RESP;
  assign Data_o = !ready ? '0 : MemType == MEM_BYTE ? DATA_WIDTH'(resp_src[8*lane +: 8]) : resp_src;
  assign mem_req = state == RD_WAIT || state == WR_WAIT;
  assign mem_we = state == WR_WAIT;
  assign mem_type = mem_we ? MemType : MEM_WORD;
  assign mem_addr = mem_we ? addr : {addr[ADDR_WIDTH-1:OFFSET_WIDTH], OFFSET_WIDTH'(0)};
  assign mem_wdata = Write_Data;
  cache_set_array #(
    .SET_WIDTH(SET_WIDTH), .TAG_WIDTH(TAG_WIDTH), .DATA_WIDTH(DATA_WIDTH), .WAYS(WAYS)
  ) u_array (
    .clk(clk), .rst_n(rst_n), .set_idx(set_idx), .tag(tag), .hit(hit), .hit_way(hit_way),
    .rdata(rdata), .victim(victim), .wr_en(wr_en), .wr_way(wr_way), .wr_data(wr_data),
    .touch(touch), .touch_way(wr_en ? wr_way : hit_way)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      resp <= '0;
      hit_count <= '0;
      miss_count <= '0;
    end else
      case (state)
        IDLE:
          if (req_valid) begin
            if (WE) state <= WR_WAIT;
            else if (hit) hit_count <= hit_count + 1'b1;
            else begin
              miss_count <= miss_count + 1'b1;
              state <= RD_WAIT;
            end
          end
        RD_WAIT:
          if (mem_ack) begin
            resp <= mem_rdata;
            state <= RESP;
          end
        WR_WAIT: if (mem_ack) state <= RESP;
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_set_assoc_cached_memory.sv
// tb_set_assoc_cached_memory: directed scoreboard bench with a latency-configurable backing memory
module tb_set_assoc_cached_memory;
  logic clk = 0, rst_n = 0, req_valid = 0, WE = 0, MemType = 0, mem_ack = 0;
  logic [31:0] addr = 0, Write_Data = 0, mem_rdata = 0;
  logic [31:0] Data_o, mem_addr, mem_wdata, hit_count, miss_count;
  logic ready, mem_req, mem_we, mem_type;
  int checks = 0, errors = 0, cnt = 0, lat = 3;
  bit ack_en = 1;
  logic [31:0] sb[$];
  logic [31:0] mem_model [logic [31:0]];
  logic [31:0] last_addr = 0, last_wdata = 0, w;
  logic last_we = 0, last_type = 0;

  set_assoc_cached_memory dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .addr(addr), .Write_Data(Write_Data),
    .WE(WE), .MemType(MemType), .Data_o(Data_o), .ready(ready), .mem_req(mem_req),
    .mem_we(mem_we), .mem_type(mem_type), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rd(input logic [31:0] a);
    return mem_model.exists(a) ? mem_model[a] : 32'h0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // backing memory: acks on the lat-th cycle of mem_req and applies writes
  initial forever begin
    @(posedge clk);
    #1;
    if (ack_en) mem_ack = 0;
    if (ack_en && mem_req) begin
      cnt++;
      if (cnt == lat) begin
        cnt = 0;
        mem_ack = 1;
        last_addr = mem_addr;
        last_we = mem_we;
        last_type = mem_type;
        last_wdata = mem_wdata;
        if (!mem_we) mem_rdata = rd(mem_addr);
        else if (mem_type) begin
          w = rd({mem_addr[31:2], 2'b00});
          w[8*mem_addr[1:0] +: 8] = mem_wdata[7:0];
          mem_model[{mem_addr[31:2], 2'b00}] = w;
        end else mem_model[mem_addr] = mem_wdata;
      end
    end else cnt = 0;
  end

  task automatic access(input string tag, input logic we_i, input logic mt_i, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] exp_d, input int exp_lat);
    int n = 0;
    logic [31:0] e;
    @(negedge clk);
    req_valid = 1; WE = we_i; MemType = mt_i; addr = a; Write_Data = wd;
    if (!we_i) sb.push_back(exp_d);
    #1;
    while (!ready && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk({tag, " latency"}, n, exp_lat);
    if (exp_lat == 0) chk({tag, " mem_req on hit"}, 32'(mem_req), 32'h0);
    if (!we_i && sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, " data"}, Data_o, e);
    end
    @(negedge clk);
    req_valid = 0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 0;
    #2;
    rst_n = 1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    mem_model[32'h040] = 32'hDEADBEEF;
    mem_model[32'h000] = 32'hAAAA0000;
    mem_model[32'h100] = 32'hBBBB0100;
    mem_model[32'h200] = 32'hCCCC0200;
    #12;
    chk("reset ready", 32'(ready), 0);
    chk("reset mem_req", 32'(mem_req), 0);
    chk("reset mem_we", 32'(mem_we), 0);
    chk("reset Data_o", Data_o, 0);
    chk("reset hit_count", hit_count, 0);
    chk("reset miss_count", miss_count, 0);
    @(negedge clk);
    rst_n = 1;
    access("miss 0x40", 0, 0, 32'h040, 0, 32'hDEADBEEF, 4);
    chk("refill addr", last_addr, 32'h040);
    chk("refill we", 32'(last_we), 0);
    chk("refill type", 32'(last_type), 0);
    access("hit 0x40", 0, 0, 32'h040, 0, 32'hDEADBEEF, 0);
    chk("A hit_count", hit_count, 1);
    chk("A miss_count", miss_count, 1);

    pulse_reset();
    chk("B reset hit_count", hit_count, 0);
    access("miss 0x000", 0, 0, 32'h000, 0, 32'hAAAA0000, 4);
    access("miss 0x100", 0, 0, 32'h100, 0, 32'hBBBB0100, 4);
    access("hit 0x000", 0, 0, 32'h000, 0, 32'hAAAA0000, 0);
    access("miss 0x200", 0, 0, 32'h200, 0, 32'hCCCC0200, 4);
    access("still hit 0x000", 0, 0, 32'h000, 0, 32'hAAAA0000, 0);
    access("evicted 0x100", 0, 0, 32'h100, 0, 32'hBBBB0100, 4);
    chk("B hit_count", hit_count, 2);
    chk("B miss_count", miss_count, 4);

    pulse_reset();
    mem_model[32'h040] = 32'h11223344;
    access("miss 0x40 C", 0, 0, 32'h040, 0, 32'h11223344, 4);
    access("byte store 0x42", 1, 1, 32'h042, 32'hFFFFFFAB, 0, 4);
    chk("store type", 32'(last_type), 1);
    chk("store we", 32'(last_we), 1);
    chk("store addr", last_addr, 32'h042);
    chk("store byte", last_wdata & 32'hFF, 32'hAB);
    access("merged word 0x40", 0, 0, 32'h040, 0, 32'h11AB3344, 0);
    access("byte load 0x42", 0, 1, 32'h042, 0, 32'h000000AB, 0);
    access("byte load 0x43", 0, 1, 32'h043, 0, 32'h00000011, 0);
    chk("C hit_count", hit_count, 3);
    chk("C miss_count", miss_count, 1);

    lat = 2;
    access("store miss 0x80", 1, 0, 32'h080, 32'h55667788, 0, 3);
    chk("store miss addr", last_addr, 32'h080);
    chk("store no count", miss_count, 1);
    access("load 0x80 after store", 0, 0, 32'h080, 0, 32'h55667788, 3);
    chk("D miss_count", miss_count, 2);
    lat = 3;

    ack_en = 0;
    @(negedge clk);
    req_valid = 1; WE = 0; MemType = 0; addr = 32'h0C0;
    @(negedge clk);
    @(negedge clk);
    chk("E mem_req in RD_WAIT", 32'(mem_req), 1);
    #2;
    rst_n = 0;
    #1;
    chk("E async mem_req drop", 32'(mem_req), 0);
    chk("E ready in reset", 32'(ready), 0);
    req_valid = 0;
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    mem_ack = 1;
    @(negedge clk);
    mem_ack = 0;
    @(negedge clk);
    chk("E late ack mem_req", 32'(mem_req), 0);
    chk("E late ack ready", 32'(ready), 0);
    chk("E miss_count cleared", miss_count, 0);
    ack_en = 1;
    access("E refetch 0x40", 0, 0, 32'h040, 0, 32'h11AB3344, 4);
    chk("E miss_count", miss_count, 1);
    chk("E hit_count", hit_count, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
